// File: rtl/pkt_err_detector_p_pkg.sv
// pkt_err_pkg: shared state, error-code and check-mode definitions for the packet error detector
package pkt_err_pkg;
    typedef enum logic [2:0] {HUNT, HDR1, BODY, CHK, GAP} state_t;
    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_SHORT = 3'd1,
        ERR_LONG  = 3'd2,
        ERR_CHK   = 3'd3,
        ERR_HDR   = 3'd4
    } err_code_t;
    localparam int CHK_SUM = 0;
    localparam int CHK_XOR = 1;
endpackage

// File: rtl/pkt_err_detector_p_if.sv
// pkt_err_detector_p_if: byte stream in, packet status out
interface pkt_err_detector_p_if #(parameter int CNT_W = 16);
    logic [7:0]       data;
    logic             data_valid;
    logic             error;
    logic [2:0]       err_code;
    logic             pkt_ok;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;
    modport master (output data, data_valid, input error, err_code, pkt_ok, good_cnt, bad_cnt);
    modport slave  (input data, data_valid, output error, err_code, pkt_ok, good_cnt, bad_cnt);
endinterface

// File: rtl/pkt_err_detector_p_accum.sv
// pkt_chk_accum: registered 8-bit body checksum, modulo-256 sum or XOR fold
module pkt_chk_accum
    import pkt_err_pkg::*;
#(
    parameter int CHK_MODE = CHK_SUM
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);
    logic [7:0] acc_d, acc_q;
    always_comb acc_d = clr ? 8'd0 : en ? (CHK_MODE == CHK_XOR ? acc_q ^ din : acc_q + din) : acc_q;
    always_ff @(posedge clk) begin
        if (!reset) acc_q <= 8'd0;
        else acc_q <= acc_d;
    end
    assign acc = acc_q;
endmodule

// File: rtl/pkt_err_detector_p.sv
// pkt_err_detector_p: frames SYNC0 SYNC1 body check packets and reports malformed ones
module pkt_err_detector_p
    import pkt_err_pkg::*;
#(
    parameter logic [7:0] SYNC0    = 8'hBE,
    parameter logic [7:0] SYNC1    = 8'hEF,
    parameter int         BODY_LEN = 8,
    parameter int         CHK_MODE = CHK_SUM,
    parameter int         CNT_W    = 16
) (
    input logic               clk,
    input logic               reset,
    pkt_err_detector_p_if.slave bus
);
    localparam logic [7:0] LAST = 8'(BODY_LEN - 1);
    state_t           state_d, state_q;
    logic [7:0]       cnt_d, cnt_q;
    logic             error_d, error_q;
    err_code_t        code_d, code_q;
    logic             pkt_ok_d, pkt_ok_q;
    logic [CNT_W-1:0] good_d, good_q, bad_d, bad_q;
    err_code_t        ev;
    logic             clr, en, ok, clear_err;
    logic [7:0]       acc;
    logic             is_s0, is_s1;

    assign is_s0 = bus.data == SYNC0;
    assign is_s1 = bus.data == SYNC1;

    pkt_chk_accum #(.CHK_MODE(CHK_MODE)) u_accum (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .en   (en),
        .din  (bus.data),
        .acc  (acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ev        = ERR_NONE;
        ok        = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        clear_err = 1'b0;
        if (bus.data_valid) begin
            case (state_q)
                HUNT: state_d = is_s0 ? HDR1 : HUNT;
                HDR1: begin
                    state_d = is_s1 ? BODY : is_s0 ? HDR1 : HUNT;
                    clr     = is_s1;
                    cnt_d   = is_s1 ? 8'd0 : cnt_q;
                    ev      = (is_s1 || is_s0) ? ERR_NONE : ERR_HDR;
                end
                BODY: begin
                    en        = !is_s0;
                    clear_err = !is_s0 && cnt_q == 8'd0;
                    cnt_d     = is_s0 ? cnt_q : cnt_q + 8'd1;
                    state_d   = is_s0 ? HDR1 : cnt_q == LAST ? CHK : BODY;
                    ev        = is_s0 ? ERR_SHORT : ERR_NONE;
                end
                CHK: begin
                    ok      = !is_s0 && bus.data == acc;
                    state_d = is_s0 ? HDR1 : GAP;
                    ev      = is_s0 ? ERR_SHORT : ok ? ERR_NONE : ERR_CHK;
                end
                GAP: begin
                    state_d = is_s0 ? HDR1 : HUNT;
                    ev      = is_s0 ? ERR_NONE : ERR_LONG;
                end
                default: state_d = HUNT;
            endcase
        end
        // a fresh error always wins over the first-body-byte clear
        error_d  = ev != ERR_NONE ? 1'b1 : clear_err ? 1'b0 : error_q;
        code_d   = ev != ERR_NONE ? ev : clear_err ? ERR_NONE : code_q;
        pkt_ok_d = ok;
        good_d   = ok && !(&good_q) ? good_q + 1'b1 : good_q;
        bad_d    = ev != ERR_NONE && !(&bad_q) ? bad_q + 1'b1 : bad_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= HUNT;
            cnt_q    <= 8'd0;
            error_q  <= 1'b0;
            code_q   <= ERR_NONE;
            pkt_ok_q <= 1'b0;
            good_q   <= '0;
            bad_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
            code_q   <= code_d;
            pkt_ok_q <= pkt_ok_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
        end
    end

    assign bus.error    = error_q;
    assign bus.err_code = code_q;
    assign bus.pkt_ok   = pkt_ok_q;
    assign bus.good_cnt = good_q;
    assign bus.bad_cnt  = bad_q;
endmodule

// File: tb/tb_pkt_err_detector_p.sv
// tb_pkt_err_detector_p: default and XOR/short/narrow-counter instances against a packet-level model
module tb_pkt_err_detector_p;
    localparam logic [7:0] S0 = 8'hBE;
    localparam logic [7:0] S1 = 8'hEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic gaps = 1'b0;
    int   n_vec = 0;
    int   n_mis = 0;

    int         ph[2], nb[2], m_good[2], m_bad[2];
    logic       m_err[2], m_ok[2];
    logic [2:0] m_code[2];
    logic [7:0] bufm[2][256];
    int         L[2]  = '{8, 2};
    int         M[2]  = '{0, 1};
    int         MX[2] = '{65535, 3};

    always #5 clk = ~clk;

    pkt_err_detector_p_if #(.CNT_W(16)) if0 ();
    pkt_err_detector_p_if #(.CNT_W(2))  if1 ();

    pkt_err_detector_p u0 (.clk(clk), .reset(rst_n), .bus(if0.slave));
    pkt_err_detector_p #(.BODY_LEN(2), .CHK_MODE(1), .CNT_W(2)) u1 (.clk(clk), .reset(rst_n), .bus(if1.slave));

    task automatic cmp(input string n, input int a, input int e);
        n_vec++;
        if (a != e) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0d, want %0d", n, $time, a, e);
        end
    endtask

    task automatic mstep(input int k, input logic rn, input logic vv, input logic [7:0] d);
        int c;
        logic [7:0] s;
        if (!rn) begin
            ph[k] = 0; nb[k] = 0; m_err[k] = 0; m_code[k] = 0;
            m_ok[k] = 0; m_good[k] = 0; m_bad[k] = 0;
            return;
        end
        m_ok[k] = 0;
        if (!vv) return;
        c = 0;
        case (ph[k])
            0: if (d == S0) ph[k] = 1;
            1: if (d == S1) begin ph[k] = 2; nb[k] = 0; end
               else if (d != S0) begin c = 4; ph[k] = 0; end
            2: if (d == S0) begin c = 1; ph[k] = 1; end
               else begin
                   bufm[k][nb[k]] = d;
                   nb[k]++;
                   if (nb[k] == 1) begin m_err[k] = 0; m_code[k] = 0; end
                   if (nb[k] == L[k]) ph[k] = 3;
               end
            3: begin
                s = 8'd0;
                for (int i = 0; i < L[k]; i++) s = M[k] != 0 ? s ^ bufm[k][i] : s + bufm[k][i];
                if (d == S0) begin c = 1; ph[k] = 1; end
                else if (d == s) begin m_ok[k] = 1; if (m_good[k] < MX[k]) m_good[k]++; ph[k] = 4; end
                else begin c = 3; ph[k] = 4; end
            end
            4: if (d == S0) ph[k] = 1; else begin c = 2; ph[k] = 0; end
            default: ;
        endcase
        if (c != 0) begin
            m_err[k] = 1;
            m_code[k] = c[2:0];
            if (m_bad[k] < MX[k]) m_bad[k]++;
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            cmp("err0",  int'(if0.error),    int'(m_err[0]));
            cmp("code0", int'(if0.err_code), int'(m_code[0]));
            cmp("ok0",   int'(if0.pkt_ok),   int'(m_ok[0]));
            cmp("good0", int'(if0.good_cnt), m_good[0]);
            cmp("bad0",  int'(if0.bad_cnt),  m_bad[0]);
            cmp("err1",  int'(if1.error),    int'(m_err[1]));
            cmp("code1", int'(if1.err_code), int'(m_code[1]));
            cmp("ok1",   int'(if1.pkt_ok),   int'(m_ok[1]));
            cmp("good1", int'(if1.good_cnt), m_good[1]);
            cmp("bad1",  int'(if1.bad_cnt),  m_bad[1]);
        end
    end

    task automatic tick(input logic rn, input logic vv, input logic [7:0] d);
        rst_n = rn;
        if0.data_valid = vv; if1.data_valid = vv;
        if0.data = d; if1.data = d;
        @(posedge clk);
        mstep(0, rn, vv, d);
        mstep(1, rn, vv, d);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        while (gaps && $urandom_range(0, 2) == 0) tick(1'b1, 1'b0, 8'($urandom));
        tick(1'b1, 1'b1, d);
    endtask

    task automatic send_pkt(input int k, input logic bad_chk);
        logic [7:0] s, b;
        s = 8'd0;
        send(S0);
        send(S1);
        for (int i = 0; i < L[k]; i++) begin
            b = 8'($urandom);
            if (b == S0 && $urandom_range(0, 3) != 0) b = 8'h11;
            s = M[k] != 0 ? s ^ b : s + b;
            send(b);
        end
        send(bad_chk ? s ^ 8'($urandom_range(1, 255)) : s);
    endtask

    task automatic chk_zero(input string n);
        cmp({n, "_err0"},  int'(if0.error), 0);
        cmp({n, "_code0"}, int'(if0.err_code), 0);
        cmp({n, "_ok0"},   int'(if0.pkt_ok), 0);
        cmp({n, "_good0"}, int'(if0.good_cnt), 0);
        cmp({n, "_bad0"},  int'(if0.bad_cnt), 0);
        cmp({n, "_good1"}, int'(if1.good_cnt), 0);
        cmp({n, "_bad1"},  int'(if1.bad_cnt), 0);
    endtask

    initial begin
        if0.data = 8'd0; if0.data_valid = 1'b0;
        if1.data = 8'd0; if1.data_valid = 1'b0;
        @(negedge clk);
        tick(1'b0, 1'b0, 8'd0);
        run = 1'b1;
        chk_zero("rst");
        // good packet, sum of 1..8 is 0x24
        send(S0); send(S1);
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h24);
        cmp("p1_ok", int'(if0.pkt_ok), 1);
        cmp("p1_good", int'(if0.good_cnt), 1);
        cmp("p1_err", int'(if0.error), 0);
        send(S0);
        cmp("p1_ok_drop", int'(if0.pkt_ok), 0);
        send(S1);
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h25);
        cmp("p2_err", int'(if0.error), 1);
        cmp("p2_code", int'(if0.err_code), 3);
        cmp("p2_bad", int'(if0.bad_cnt), 1);
        send(S0); send(S1); send(8'h01);
        cmp("p2_clear", int'(if0.error), 0);
        cmp("p2_clear_code", int'(if0.err_code), 0);
        for (int i = 2; i <= 8; i++) send(8'(i));
        send(8'h24);
        cmp("p2_good", int'(if0.good_cnt), 2);
        send(S0); send(S1); send(8'h01); send(8'h02); send(8'h03); send(S0);
        cmp("p3_code", int'(if0.err_code), 1);
        cmp("p3_bad", int'(if0.bad_cnt), 2);
        send(S1);
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h24);
        cmp("p3_ok", int'(if0.pkt_ok), 1);
        cmp("p3_good", int'(if0.good_cnt), 3);
        send(8'h77);
        cmp("p4_code", int'(if0.err_code), 2);
        cmp("p4_bad", int'(if0.bad_cnt), 3);
        send(S0); send(S1); send(8'h00);
        cmp("p4_clear", int'(if0.error), 0);
        tick(1'b0, 1'b1, 8'h00);
        chk_zero("rst2");
        send(S0); send(8'h12);
        cmp("p5_code", int'(if0.err_code), 4);
        cmp("p5_bad", int'(if0.bad_cnt), 1);
        send(S0); send(S0); send(S1);
        cmp("p5_bad_hold", int'(if0.bad_cnt), 1);
        gaps = 1'b1;
        send(8'h01);
        cmp("p5_clear", int'(if0.error), 0);
        for (int i = 2; i <= 8; i++) send(8'(i));
        send(8'h24);
        gaps = 1'b0;
        cmp("p5_gap_ok", int'(if0.pkt_ok), 1);
        tick(1'b0, 1'b0, 8'h00);
        // XOR instance: 0F ^ F0 = FF; counter is 2 bits wide
        for (int p = 0; p < 5; p++) begin
            send(S0); send(S1); send(8'h0F); send(8'hF0); send(8'hFF);
            if (p == 0) cmp("x_ok", int'(if1.pkt_ok), 1);
        end
        cmp("x_sat", int'(if1.good_cnt), 3);
        send(S0); send(S1); send(8'h01); send(8'h02);
        tick(1'b0, 1'b1, 8'h03);
        chk_zero("rst_mid");
        send(8'h03);
        cmp("rst_mid_noerr", int'(if0.error), 0);
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            gaps = $urandom_range(0, 2) == 0;
            if (r <= 3) send_pkt(0, $urandom_range(0, 4) == 0);
            else if (r <= 6) send_pkt(1, $urandom_range(0, 4) == 0);
            else if (r <= 8) send($urandom_range(0, 2) == 0 ? S0 : $urandom_range(0, 1) == 0 ? S1 : 8'($urandom));
            else if ($urandom_range(0, 7) == 0) tick(1'b0, 1'b1, 8'($urandom));
            else tick(1'b1, 1'b0, S0);
        end
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/pkt_err_detector_p.md
Name: pkt_err_detector_p

Overview:
- Parametrised successor to the fixed 11-byte packet error detector.
- Monitors an 8-bit byte stream with a valid qualifier. Frames packets as {SYNC0, SYNC1, BODY_LEN body bytes, 1 check byte}.
- Flags malformed packets with a sticky error, a classified error code, a good-packet pulse and saturating good/bad packet counters.
- Sits on the receive side between the byte deserialiser and the packet consumer. Status only; it never modifies data.

Parameters:
- SYNC0, 8'hBE, first header byte. Never legal in body or check byte.
- SYNC1, 8'hEF, second header byte.
- BODY_LEN, 8, body bytes per packet. Legal range 1..255.
- CHK_MODE, 0, check-byte algorithm: 0 = sum of body mod 256, 1 = XOR of body bytes.
- CNT_W, 16, width of the packet counters.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- reset, input, 1, synchronous, active-low. Low at a rising edge resets all state.
- data, input, 8, stream byte.
- data_valid, input, 1, byte on data is accepted this cycle. Invalid cycles are ignored entirely.
- error, output, 1, sticky packet-error flag.
- err_code, output, 3, cause of the latest error: 0 none, 1 short, 2 long, 3 checksum, 4 header.
- pkt_ok, output, 1, one-cycle pulse for a correct packet.
- good_cnt, output, CNT_W, count of correct packets, saturating.
- bad_cnt, output, CNT_W, count of error events, saturating.

Behaviour:
- All outputs registered. Every response appears the cycle after the accepted byte that causes it.
- Reset values:
  - error=0, err_code=0, pkt_ok=0, good_cnt=0, bad_cnt=0.
  - FSM=HUNT, accumulator=0, body counter=0.
- Reset mid-packet discards the partial packet with no error.
- FSM states: HUNT, HDR1, BODY, CHK, GAP. Only accepted bytes cause transitions.
- HUNT:
  - SYNC0 -> HDR1.
  - Anything else is ignored. This covers pre-first-packet garbage and post-error resync.
- HDR1:
  - SYNC1 -> BODY; clear accumulator and counter.
  - SYNC0 -> stay in HDR1.
  - Other -> header error (code 4), -> HUNT.
- BODY:
  - SYNC0 -> short error (code 1), -> HDR1 (treated as the start of a new packet).
  - Other byte -> fold into accumulator and increment counter. After BODY_LEN bytes -> CHK.
  - SYNC1 in body is ordinary data.
- CHK:
  - SYNC0 -> short error (code 1), -> HDR1.
  - Byte equal to accumulator -> pkt_ok pulse, good_cnt+1, -> GAP.
  - Byte not equal -> checksum error (code 3), -> GAP.
- GAP:
  - SYNC0 -> HDR1.
  - Other -> long error (code 2), -> HUNT.
- Accumulator: 8-bit. Sum mode wraps modulo 256; XOR mode is a plain XOR fold.
- Error event rules:
  - error<=1, err_code<=cause, bad_cnt+1.
  - Exactly one event per accepted byte.
  - A later event overwrites err_code.
- Error clear:
  - error and err_code return to 0 the cycle after the first body byte (byte 2) of a subsequent packet is accepted in BODY.
  - If that byte itself raises an error (SYNC0), the error persists and takes the new code.
- Counters saturate at all-ones and do not wrap.
- pkt_ok and an error event never occur in the same cycle.

Decomposition:
- Package pkt_err_pkg holds:
  - state enum {HUNT, HDR1, BODY, CHK, GAP};
  - err_code enum {ERR_NONE=0, ERR_SHORT=1, ERR_LONG=2, ERR_CHK=3, ERR_HDR=4};
  - CHK_SUM=0 and CHK_XOR=1 constants.
- Sub-module pkt_chk_accum: the CHK_MODE-parametrised 8-bit accumulator with clear and enable inputs and a registered result.
- FSM, error flag and counters stay in the top module.

Test Plan:
- Default parameters, stream BE EF 01 02 03 04 05 06 07 08 24 BE EF 00…:
  - pkt_ok pulses once after 24;
  - good_cnt=1, error=0 throughout.
- Same packet with check byte 25:
  - error=1, err_code=3 the cycle after 25;
  - error drops the cycle after byte 2 of the next good packet;
  - bad_cnt=1.
- BE EF 01 02 03 BE EF …:
  - short error (code 1) after the second BE;
  - the following packet is parsed normally.
- Good packet then extra byte 77:
  - long error (code 2) after 77;
  - the next BE EF 00 clears error after 00.
- BE 12: header error (code 4). BE BE EF: no error; parsing proceeds.
- Edge and mode cases:
  - CHK_MODE=1, BODY_LEN=2, CNT_W=2: body 0F F0 with check FF gives pkt_ok.
  - Five good packets saturate good_cnt at 3.
  - data_valid gaps inside a packet change nothing.
  - Reset low mid-body returns every output to 0.
